// File: rtl/icache_refill_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg
// Shared constants and types for the direct-mapped instruction cache and its
// refill path: word/line geometry, beat-counter width, refill FSM encoding and
// a line-alignment helper.
// -----------------------------------------------------------------------------
package icache_refill_pkg;

   localparam int WORD_SIZE  = 32;                     // bits per instruction word
   localparam int LINE_WORDS = 32;                     // words per cache line
   localparam int BLOCK_SIZE = WORD_SIZE * LINE_WORDS; // 1024-bit line
   localparam int LINE_BYTES = 128;
   localparam int OFFSET_W   = $clog2(LINE_BYTES);     // byte offset inside a line
   localparam int BEAT_W     = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } refill_state_e;

   // Clear the byte-offset bits so the address names the start of its line.
   function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] addr);
      return addr & ~(WORD_SIZE'(LINE_BYTES - 1));
   endfunction

endpackage

// File: rtl/icache_line_buf.sv
// -----------------------------------------------------------------------------
// icache_line_buf
// Assembly buffer for one cache line during refill. Incoming words are placed
// at the position fetch expects (word k at the top end, walking downwards) so
// the finished line can be copied into the data array unchanged.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset (counter and flag only)
//   clr_i        restart the beat counter for a new line
//   wr_en_i      store wdata_i as the next word (ignored once full)
//   wdata_i      refill word
//   line_o       assembled line
//   beat_o       index of the word the next write will fill
//   full_o       all LINE_WORDS words have been written
// -----------------------------------------------------------------------------
module icache_line_buf
   import icache_refill_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  wr_en_i,
   input  logic [WORD_SIZE-1:0]  wdata_i,
   output logic [BLOCK_SIZE-1:0] line_o,
   output logic [BEAT_W-1:0]     beat_o,
   output logic                  full_o
);

   logic [BLOCK_SIZE-1:0] line_q;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  full_q, full_d;
   logic                  wr_ok;

   assign wr_ok = wr_en_i && !full_q;

   always_comb begin
      beat_d = beat_q;
      full_d = full_q;
      if (clr_i) begin
         beat_d = '0;
         full_d = 1'b0;
      end else if (wr_ok) begin
         // Counter wraps to 0 on the last word; full_q keeps further writes out.
         beat_d = beat_q + BEAT_W'(1);
         full_d = (beat_q == BEAT_W'(LINE_WORDS - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
         full_q <= 1'b0;
      end else begin
         beat_q <= beat_d;
         full_q <= full_d;
      end
   end

   // Data storage carries no reset: a partial line is never installed.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         line_q[(BLOCK_SIZE - 1) - (int'(beat_q) * WORD_SIZE) -: WORD_SIZE] <= wdata_i;
      end
   end

   assign line_o = line_q;
   assign beat_o = beat_q;
   assign full_o = full_q;

endmodule

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
// Direct-mapped instruction cache serving whole lines to fetch. Lookup is
// combinational; a miss seen in IDLE starts a single refill that fetches the
// line word by word from memory and installs it. Lookups to other lines keep
// hitting while a refill is in flight.
//
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   req_valid, in    fetch lookup strobe and pc (byte address, [6:0] ignored)
//   out, hit         line data (meaningful only when hit) and hit flag
//   mem_req_valid    refill request, held until mem_req_ready
//   mem_req_ready    memory accepts the request
//   mem_addr         line-aligned refill address
//   mem_resp_valid   one refill word present on mem_resp_data
//   mem_resp_data    refill word, ascending word order
//   hit_count,       (only with ICACHE_STATS_EN defined) wrapping counters of
//   miss_count        cycles with a hit and of refills started
// -----------------------------------------------------------------------------
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter int NUM_LINES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic [WORD_SIZE-1:0]  in,
   output logic [BLOCK_SIZE-1:0] out,
   output logic                  hit,
`ifdef ICACHE_STATS_EN
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count,
`endif
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [WORD_SIZE-1:0]  mem_addr,
   input  logic                  mem_resp_valid,
   input  logic [WORD_SIZE-1:0]  mem_resp_data
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = WORD_SIZE - OFFSET_W - IDX_W;

   refill_state_e          state_q, state_d;
   logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [BLOCK_SIZE-1:0]  data_q [NUM_LINES];

   logic [IDX_W-1:0]       lk_idx, fill_idx;
   logic [TAG_W-1:0]       lk_tag, fill_tag;
   logic                   miss_start, install;
   logic                   buf_clr, buf_wr, buf_full;
   logic [BEAT_W-1:0]      buf_beat;
   logic [BLOCK_SIZE-1:0]  buf_line;

   // Lookup side
   assign lk_idx = in[OFFSET_W +: IDX_W];
   assign lk_tag = in[WORD_SIZE-1 -: TAG_W];
   assign hit    = req_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign out    = data_q[lk_idx];

   // Refill side works from the latched address, not the live pc.
   assign fill_idx = mem_addr_q[OFFSET_W +: IDX_W];
   assign fill_tag = mem_addr_q[WORD_SIZE-1 -: TAG_W];
   assign mem_addr = mem_addr_q;

   icache_line_buf u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (buf_clr),
      .wr_en_i (buf_wr),
      .wdata_i (mem_resp_data),
      .line_o  (buf_line),
      .beat_o  (buf_beat),
      .full_o  (buf_full)
   );

   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      mem_req_valid = 1'b0;
      miss_start    = 1'b0;
      install       = 1'b0;
      buf_clr       = 1'b0;
      buf_wr        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid && !hit) begin
               mem_addr_d = line_align(in);
               miss_start = 1'b1;
               state_d    = REQ;
            end
         end
         REQ: begin
            // Decoded straight from state so an async reset drops it at once.
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               buf_clr = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            if (mem_resp_valid && !buf_full) begin
               buf_wr = 1'b1;
               if (buf_beat == BEAT_W'(LINE_WORDS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            install = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Invalidate the victim as soon as the refill starts so a lookup to the
   // line being replaced cannot hit stale data mid-fill.
   always_comb begin
      valid_d = valid_q;
      if (miss_start) valid_d[lk_idx]   = 1'b0;
      if (install)    valid_d[fill_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         valid_q    <= valid_d;
      end
   end

   // Tag and data arrays are qualified by valid_q and need no reset.
   always_ff @(posedge clk) begin
      if (install) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= buf_line;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit)        hit_cnt_d  = hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Direct-mapped instruction cache sitting directly upstream of the fetch stage.
- Serves whole 1024-bit (128-byte, 32-word) lines to fetch, which walks words from the top bits down.
- On a miss, a refill FSM pulls the line word-by-word from the memory model and installs it.
- Fetch presents a line-aligned pc; it polls `hit` and retries until hit.

Parameters:
- WORD_SIZE, 32, bits per instruction word.
- LINE_WORDS, 32, words per line (BLOCK_SIZE = WORD_SIZE*LINE_WORDS = 1024).
- NUM_LINES, 8, cache lines (power of two); index = addr[7+log2(NUM_LINES)-1:7].

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch lookup valid.
- in  in  WORD_SIZE  fetch pc (byte address; bits [6:0] ignored).
- out  out  BLOCK_SIZE  line data; word k at bits [BLOCK_SIZE-1-k*WORD_SIZE -: WORD_SIZE].
- hit  out  1  line for `in` present and valid.
- mem_req_valid  out  1  refill request.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  WORD_SIZE  line-aligned refill address (in & ~127).
- mem_resp_valid  in  1  one refill word this cycle.
- mem_resp_data  in  WORD_SIZE  refill word, ascending order k=0..LINE_WORDS-1.

Behaviour:
- Reset: all valid bits 0; FSM IDLE; mem_req_valid=0; mem_addr=0; beat counter=0; hit=0. Tag/data arrays are not cleared.
- Lookup is combinational, same cycle:
  - hit = req_valid & valid[idx] & (tag[idx]==in tag).
  - out = data[idx], undefined unless hit.
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE: if req_valid & !hit at posedge:
  - latch miss address (line-aligned) into mem_addr;
  - clear valid[idx];
  - go to REQ.
- REQ: mem_req_valid=1; on posedge with mem_req_ready, drop mem_req_valid and go to FILL with beat=0.
- FILL: each posedge with mem_resp_valid:
  - write mem_resp_data into word `beat` of a line buffer; beat++.
  - On beat==LINE_WORDS-1 write, go to DONE.
  - Gaps in mem_resp_valid are allowed and wait indefinitely.
- DONE (1 cycle): copy buffer to data[idx], set tag[idx], valid[idx]=1, return to IDLE. hit for the filled line is visible the cycle after DONE.
- Miss latency, with ready and resp asserted continuously: 1 (IDLE→REQ) + 1 (REQ) + 32 beats + 1 (DONE) = 35 cycles from first miss edge to hit.
- `in` changes during refill: the refill completes for the latched address and the line is installed. The new address is then looked up in IDLE and may trigger a second refill.
- Lookups hitting other lines during REQ/FILL/DONE return hit normally (hit-under-miss); a lookup to the line being filled returns hit=0.
- Only one outstanding refill at a time; misses while busy do not queue.
- mem_resp_valid in IDLE/REQ/DONE is ignored.
- Asynchronous reset mid-refill: immediate return to IDLE; valid all 0; mem_req_valid drops asynchronously; partial buffer discarded. The memory model must not deliver stale beats after reset.
- Same-index conflict: a refill overwrites the resident line; no writeback (read-only cache).

Optional Feature:
- ICACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments each posedge with req_valid & hit.
  - miss_count increments on each IDLE→REQ transition.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/define file (define.v): WORD_SIZE, BLOCK_SIZE, LINE_BYTES=128, FSM state encodings (IDLE=2'd0, REQ=2'd1, FILL=2'd2, DONE=2'd3).
- One natural sub-module: icache_line_buf, a LINE_WORDS×WORD_SIZE shift/indexed buffer with write-enable, beat counter and `full` flag.

Test Plan:
- Cold miss: reset, req_valid=1, in=0x00000000, memory returns words 0x10000000+k with no gaps → mem_addr=0x0, hit=1 exactly 35 cycles later, out[1023:992]=0x10000000, out[31:0]=0x1000001F.
- Line hit: after above, in=0x00000040 → hit same cycle, no mem_req_valid, same out.
- Conflict: in=0x00000400 (NUM_LINES=8, same index 0) → refill from 0x400; then in=0x0 → hit=0 and new refill issued.
- Gapped refill: mem_resp_valid toggling 1/0 each cycle, mem_req_ready delayed 5 cycles → correct line, hit after 1+6+63+1 cycles.
- Reset mid-FILL after 10 beats → mem_req_valid=0, hit=0 for all addresses; subsequent request re-fetches the full line correctly.
- With ICACHE_STATS_EN: one cold miss then 4 hit cycles → miss_count=1, hit_count=4.
